// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, selector
// codes, FSM state constants and error codes.
package mips_pkg;

    // IR[31:26] opcodes understood by the sequencer
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU control class
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ITYPE = 2'b11;

    // ALU B operand select
    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Error codes (sticky until reset)
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // FSM state encoding (4 bits)
    typedef logic [3:0] state_t;
    localparam state_t ST_BOOT   = 4'd0;
    localparam state_t ST_FETCH  = 4'd1;
    localparam state_t ST_DECODE = 4'd2;
    localparam state_t ST_MEMADR = 4'd3;
    localparam state_t ST_MEMRD  = 4'd4;
    localparam state_t ST_MEMWB  = 4'd5;
    localparam state_t ST_MEMWR  = 4'd6;
    localparam state_t ST_EXEC_R = 4'd7;
    localparam state_t ST_RWB    = 4'd8;
    localparam state_t ST_EXEC_I = 4'd9;
    localparam state_t ST_IWB    = 4'd10;
    localparam state_t ST_BRANCH = 4'd11;
    localparam state_t ST_JUMP   = 4'd12;
    localparam state_t ST_HALT   = 4'd13;

    // States that hold a request on the shared memory port
    function automatic logic is_access_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

    // Opcodes with a defined execution sequence
    function automatic logic is_known_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_ADDI) ||
               (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait-state counter with timeout compare. Counts cycles a request
// is held without mem_ready; saturates instead of wrapping.
module mc_wait_timer
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enter,      // FSM is entering an access state this cycle
    input  logic active,     // FSM is in an access state
    input  logic mem_ready,
    output logic timeout
);

    // A zero timeout still needs a 1-bit counter to keep the port legal
    localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear on entry or completion, otherwise count held-request cycles
    always_comb begin
        cnt_d = cnt_q;
        if (enter || (active && mem_ready)) begin
            cnt_d = '0;
        end else if (active && (cnt_q != CNT_SAT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Wait counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Timeout depends only on registered count, so the request it drops
    // never has a combinational path back from mem_ready
    always_comb begin
        timeout = 1'b0;
        if ((MEM_TIMEOUT != 0) && active && (cnt_q == CNT_LIMIT)) begin
            timeout = 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS sequencer: fetches over a shared memory port with a
// ready handshake, decodes the opcode and drives datapath enables/selects.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 16,
    parameter int ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_beq,
    output logic       pc_write_bne,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       retire,
    output logic       halted,
    output logic [1:0] err_code
);

    state_t     state_q;
    state_t     state_d;
    logic [1:0] err_q;
    logic [1:0] err_d;
    logic       access;
    logic       enter;
    logic       timeout;

    assign access = is_access_state(state_q);
    assign enter  = is_access_state(state_d) && (state_d != state_q);

    mc_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .enter    (enter),
        .active   (access),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    // Next-state and sticky error logic
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        case (state_q)
            ST_BOOT: begin
                if (run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (timeout) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = ST_EXEC_R;
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_ADDI:      state_d = ST_EXEC_I;
                    OP_BEQ,
                    OP_BNE:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    default: begin
                        if (ILLEGAL_HALT != 0) begin
                            state_d = ST_HALT;
                            err_d   = ERR_ILLEGAL;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end
                endcase
            end
            ST_MEMADR: begin
                state_d = (opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
            end
            ST_MEMRD: begin
                if (timeout) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = ST_MEMWB;
                end
            end
            ST_MEMWR: begin
                if (timeout) begin
                    state_d = ST_HALT;
                    err_d   = ERR_TIMEOUT;
                end else if (mem_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC_R: state_d = ST_RWB;
            ST_EXEC_I: state_d = ST_IWB;
            ST_MEMWB, ST_RWB, ST_IWB, ST_BRANCH, ST_JUMP: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_BOOT;
        endcase
    end

    // State and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            err_q   <= ERR_NONE;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    // Moore output decode; only the FETCH load enables and the final
    // MEMWR retire look at mem_ready
    always_comb begin
        pc_write     = 1'b0;
        pc_write_beq = 1'b0;
        pc_write_bne = 1'b0;
        iord         = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        reg_dst      = 1'b0;
        mem_to_reg   = 1'b0;
        reg_write    = 1'b0;
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_B;
        alu_op       = ALUOP_ADD;
        pc_source    = PCSRC_ALU;
        retire       = 1'b0;
        case (state_q)
            ST_FETCH: begin
                alu_src_b = SRCB_FOUR;
                if (!timeout) begin
                    mem_read = 1'b1;
                    ir_write = mem_ready;
                    pc_write = mem_ready;
                end
            end
            ST_DECODE: begin
                alu_src_b = SRCB_IMM_SH2;
                if ((ILLEGAL_HALT == 0) && !is_known_op(opcode)) begin
                    retire = 1'b1;
                end
            end
            ST_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            ST_MEMRD: begin
                iord     = 1'b1;
                mem_read = !timeout;
            end
            ST_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            ST_MEMWR: begin
                iord      = 1'b1;
                mem_write = !timeout;
                retire    = mem_ready && !timeout;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            ST_RWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                retire    = 1'b1;
            end
            ST_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALUOP_ITYPE;
            end
            ST_IWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a    = 1'b1;
                alu_op       = ALUOP_SUB;
                pc_source    = PCSRC_ALUOUT;
                pc_write_beq = (opcode == OP_BEQ);
                pc_write_bne = (opcode == OP_BNE);
                retire       = 1'b1;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                retire    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign halted   = (state_q == ST_HALT);
    assign err_code = err_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: every instruction is expanded
// into its expected per-cycle control vectors and compared cycle by cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       retire;
        logic       halted;
        logic [1:0] err_code;
    } ovec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;
    logic       pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       retire, halted;
    logic [1:0] err_code;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    multicycle_control #(
        .MEM_TIMEOUT (4),
        .ILLEGAL_HALT(1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .pc_write_beq(pc_write_beq),
        .pc_write_bne(pc_write_bne),
        .iord        (iord),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .pc_source   (pc_source),
        .retire      (retire),
        .halted      (halted),
        .err_code    (err_code)
    );

    ovec_t obs;
    assign obs = '{pc_write, pc_write_beq, pc_write_bne, iord, mem_read, mem_write,
                   ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
                   alu_op, pc_source, retire, halted, err_code};

    task automatic check(input ovec_t exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs mid-cycle, then compare outputs
    task automatic step(input logic rdy, input logic [5:0] op, input ovec_t exp, input string tag);
        @(negedge clk);
        mem_ready = rdy;
        opcode    = op;
        #1;
        check(exp, tag);
    endtask

    // Fetch with fw wait states, then decode (mem_ready ignored in decode)
    task automatic fetch_decode(input logic [5:0] op, input int fw);
        ovec_t v;
        for (int i = 0; i < fw; i++) begin
            v = '0; v.mem_read = 1'b1; v.alu_src_b = 2'b01;
            step(1'b0, op, v, "fetch_wait");
        end
        v = '0; v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.ir_write = 1'b1; v.pc_write = 1'b1;
        step(1'b1, op, v, "fetch_ready");
        v = '0; v.alu_src_b = 2'b11;
        step(1'($urandom_range(0, 1)), op, v, "decode");
    endtask

    // Full instruction with fw fetch waits and mw data-access waits (< timeout)
    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        ovec_t v;
        fetch_decode(op, fw);
        case (op)
            6'b100011: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
                step(1'($urandom_range(0, 1)), op, v, "lw_memadr");
                v = '0; v.mem_read = 1'b1; v.iord = 1'b1;
                for (int i = 0; i < mw; i++) step(1'b0, op, v, "lw_rd_wait");
                step(1'b1, op, v, "lw_rd_ready");
                v = '0; v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.retire = 1'b1;
                step(1'($urandom_range(0, 1)), op, v, "lw_wb");
            end
            6'b101011: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
                step(1'($urandom_range(0, 1)), op, v, "sw_memadr");
                v = '0; v.mem_write = 1'b1; v.iord = 1'b1;
                for (int i = 0; i < mw; i++) step(1'b0, op, v, "sw_wr_wait");
                v.retire = 1'b1;
                step(1'b1, op, v, "sw_wr_ready");
            end
            6'b000000: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_op = 2'b10;
                step(1'($urandom_range(0, 1)), op, v, "r_exec");
                v = '0; v.reg_write = 1'b1; v.reg_dst = 1'b1; v.retire = 1'b1;
                step(1'($urandom_range(0, 1)), op, v, "r_wb");
            end
            6'b001000: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_op = 2'b11;
                step(1'($urandom_range(0, 1)), op, v, "addi_exec");
                v = '0; v.reg_write = 1'b1; v.retire = 1'b1;
                step(1'($urandom_range(0, 1)), op, v, "addi_wb");
            end
            6'b000100, 6'b000101: begin
                v = '0; v.alu_src_a = 1'b1; v.alu_op = 2'b01; v.pc_source = 2'b01;
                v.retire = 1'b1;
                v.pc_write_beq = (op == 6'b000100);
                v.pc_write_bne = (op == 6'b000101);
                step(1'($urandom_range(0, 1)), op, v, "branch");
            end
            6'b000010: begin
                v = '0; v.pc_write = 1'b1; v.pc_source = 2'b10; v.retire = 1'b1;
                step(1'($urandom_range(0, 1)), op, v, "jump");
            end
            default: begin
                // Unknown opcode: halt with illegal-opcode error, absorbing
                for (int i = 0; i < 3; i++) begin
                    v = '0; v.halted = 1'b1; v.err_code = 2'b01;
                    step(1'($urandom_range(0, 1)), op, v, "illegal_halt");
                end
            end
        endcase
    endtask

    // Async reset mid-cycle, then idle in BOOT and start running
    task automatic reset_and_boot();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        run   = 1'b0;
        #1;
        check('0, "async_reset");
        @(negedge clk);
        #1;
        check('0, "reset_held");
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 6'($urandom), '0, "boot_idle");
        @(negedge clk);
        run = 1'b1;
        mem_ready = 1'b0;
        #1;
        check('0, "boot_run");
    endtask

    logic [5:0] legal_ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b001000,
                                  6'b000100, 6'b000101, 6'b000010};

    initial begin
        ovec_t v;
        reset_and_boot();

        // lw with zero-wait memory
        run_instr(6'b100011, 0, 0);
        // fetch with three wait states on an R-type
        run_instr(6'b000000, 3, 0);
        // bne, then beq, then j
        run_instr(6'b000101, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b000010, 0, 0);

        // Random legal instruction mix with wait states below the timeout
        for (int n = 0; n < 30; n++) begin
            run_instr(legal_ops[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // sw with mem_ready stuck low: four held cycles, then request drops and halt
        fetch_decode(6'b101011, 0);
        v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
        step(1'b0, 6'b101011, v, "to_memadr");
        v = '0; v.mem_write = 1'b1; v.iord = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b0, 6'b101011, v, "to_wr_wait");
        v = '0; v.iord = 1'b1;
        step(1'b0, 6'b101011, v, "to_drop");
        v = '0; v.halted = 1'b1; v.err_code = 2'b10;
        for (int i = 0; i < 3; i++) step(1'($urandom_range(0, 1)), 6'($urandom), v, "to_halt");

        // Reset clears the timeout error
        reset_and_boot();
        run_instr(6'b001000, 1, 0);

        // Reset while MEMRD is waiting
        fetch_decode(6'b100011, 0);
        v = '0; v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
        step(1'b0, 6'b100011, v, "mr_memadr");
        v = '0; v.mem_read = 1'b1; v.iord = 1'b1;
        for (int i = 0; i < 2; i++) step(1'b0, 6'b100011, v, "mr_rd_wait");
        reset_and_boot();

        // Counter must start clean after reset: three waits complete normally
        run_instr(6'b101011, 3, 3);
        run_instr(6'b100011, 2, 3);

        // Illegal opcode halts with error 01, then reset clears it
        run_instr(6'b111111, 0, 0);
        reset_and_boot();
        run_instr(6'b000010, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
